// File: rtl/jtag_master.sv
// Host-side JTAG initiator: expands one command (TAP reset, IR/DR scan, idle clocks)
// into TCK/TMS/TDI slots starting and ending in Run-Test/Idle, capturing TDO while shifting.
module jtag_master #(
  parameter int MAX_W      = 10,
  parameter int HALF_DIV   = 5,
  parameter int RTI_CYCLES = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [7:0]       i_cmd_len,
  input  logic [MAX_W-1:0] i_cmd_data,
  output logic             o_rsp_valid,
  output logic [MAX_W-1:0] o_rsp_data,
  output logic             o_busy,
  output logic             o_tck,
  output logic             o_tms,
  output logic             o_tdi,
  input  logic             i_tdo
);
  localparam int CW = (2*HALF_DIV > 1) ? $clog2(2*HALF_DIV) : 1;
  localparam int IW = (MAX_W > 255) ? $clog2(MAX_W+1) : 8;
  localparam logic [CW-1:0] PH_LAST = CW'(2*HALF_DIV-1);
  localparam logic [CW-1:0] PH_RISE = CW'(HALF_DIV-1);
  localparam logic [CW-1:0] PH_HIGH = CW'(HALF_DIV);

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_HDR    = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_TAIL   = 3'd4;
  localparam logic [2:0] S_RTI    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_RSTSEQ = 3'd7;

  localparam logic [1:0] OP_RST  = 2'd0;
  localparam logic [1:0] OP_IR   = 2'd1;
  localparam logic [1:0] OP_DR   = 2'd2;
  localparam logic [1:0] OP_IDLE = 2'd3;

  logic [2:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_idx;
  logic [1:0]       r_op;
  logic [IW-1:0]    r_len;
  logic [MAX_W-1:0] r_data;
  logic [MAX_W-1:0] r_rsp;

  logic             w_ready, w_run, w_slot_end, w_accept, w_tms, w_shift_last;
  logic [IW-1:0]    w_len_clamp, w_hdr_last, w_rti_last;
  logic [MAX_W-1:0] w_data_sh;

  assign w_ready      = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_run        = !w_ready;
  assign w_slot_end   = w_run && (r_cnt == PH_LAST);
  assign w_accept     = i_cmd_valid && w_ready;
  assign w_shift_last = (r_idx == r_len - IW'(1));
  assign w_hdr_last   = (r_op == OP_IR) ? IW'(3) : IW'(2);
  // op 11 spends its whole length in Run-Test/Idle; scans use the fixed tail
  assign w_rti_last   = ((r_op == OP_IDLE) ? r_len : IW'(RTI_CYCLES)) - IW'(1);
  assign w_data_sh    = r_data >> r_idx;

  always_comb begin
    w_len_clamp = IW'(i_cmd_len);
    if (i_cmd_op == OP_IR || i_cmd_op == OP_DR) begin
      if (i_cmd_len == 8'd0)                 w_len_clamp = IW'(1);
      else if (IW'(i_cmd_len) > IW'(MAX_W))  w_len_clamp = IW'(MAX_W);
    end
  end

  always_comb begin
    w_tms = 1'b0;
    case (r_state)
      S_BOOT, S_RSTSEQ: w_tms = (r_idx < IW'(5));
      S_HDR:            w_tms = (r_op == OP_IR) ? (r_idx < IW'(2)) : (r_idx == '0);
      S_SHIFT:          w_tms = w_shift_last;
      S_TAIL:           w_tms = (r_idx == '0);
      default:          w_tms = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_BOOT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_op    <= OP_RST;
      r_len   <= '0;
      r_data  <= '0;
      r_rsp   <= '0;
    end else begin
      if (w_run) r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
      // TDO is taken on the clk edge that raises TCK, i.e. before the TAP's own rising edge
      if (r_state == S_SHIFT && r_cnt == PH_RISE) r_rsp <= r_rsp | (MAX_W'(i_tdo) << r_idx);
      if (w_slot_end) r_idx <= r_idx + IW'(1);
      case (r_state)
        S_BOOT, S_RSTSEQ:
          if (w_slot_end && r_idx == IW'(5)) begin
            r_idx   <= '0;
            r_state <= (r_state == S_BOOT) ? S_IDLE : S_DONE;
          end
        S_HDR:
          if (w_slot_end && r_idx == w_hdr_last) begin
            r_idx   <= '0;
            r_state <= S_SHIFT;
          end
        S_SHIFT:
          if (w_slot_end && w_shift_last) begin
            r_idx   <= '0;
            r_state <= S_TAIL;
          end
        S_TAIL:
          if (w_slot_end && r_idx == IW'(1)) begin
            r_idx   <= '0;
            r_state <= (RTI_CYCLES == 0) ? S_DONE : S_RTI;
          end
        S_RTI:
          if (w_slot_end && r_idx == w_rti_last) begin
            r_idx   <= '0;
            r_state <= S_DONE;
          end
        default: begin
          if (w_accept) begin
            r_op   <= i_cmd_op;
            r_len  <= w_len_clamp;
            r_data <= i_cmd_data;
            r_rsp  <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            case (i_cmd_op)
              OP_RST:  r_state <= S_RSTSEQ;
              OP_IDLE: r_state <= (i_cmd_len == 8'd0) ? S_DONE : S_RTI;
              default: r_state <= S_HDR;
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign o_cmd_ready = w_ready;
  assign o_busy      = !w_ready;
  assign o_rsp_valid = (r_state == S_DONE);
  assign o_rsp_data  = r_rsp;
  assign o_tck       = w_run && (r_cnt >= PH_HIGH);
  assign o_tms       = w_tms;
  assign o_tdi       = (r_state == S_SHIFT) ? w_data_sh[0] : 1'b0;
endmodule
